// File: rtl/fetch_dec_queue.sv
// Fetch-to-decode instruction queue: small circular buffer of PC/instruction
// pairs with fetch back-pressure, sticky overflow detection and flush.
module fetch_dec_queue #(
  parameter int ADDR  = 32,
  parameter int INST  = 32,
  parameter int DEPTH = 4,
  parameter int PTR   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            flush,
  input  logic            f_inst_e_,
  input  logic [ADDR-1:0] f_inst_pc,
  input  logic [INST-1:0] f_inst,
  output logic            f_full,
  output logic            d_inst_e_,
  output logic [ADDR-1:0] d_inst_pc,
  output logic [INST-1:0] d_inst,
  input  logic            d_stall,
  output logic [PTR:0]    count,
  output logic            overflow
);

  localparam int CW = PTR + 1;
  localparam logic [PTR:0] FULL_CNT = CW'(DEPTH);

  logic [PTR-1:0]  wp_q, wp_d;
  logic [PTR-1:0]  rp_q, rp_d;
  logic [PTR:0]    count_q, count_d;
  logic            overflow_q, overflow_d;

  logic [ADDR-1:0] pc_mem   [DEPTH];
  logic [INST-1:0] inst_mem [DEPTH];

  logic push_req;
  logic full;
  logic empty;
  logic push_ok;
  logic pop;

  assign push_req = ~f_inst_e_;
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign push_ok  = push_req & ~full;
  assign pop      = ~empty & ~d_stall;

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      wp_d       = '0;
      rp_d       = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) wp_d = wp_q + PTR'(1);
      if (pop)     rp_d = rp_q + PTR'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop);
      if (push_req && full) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is never reset; outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      pc_mem[wp_q]   <= f_inst_pc;
      inst_mem[wp_q] <= f_inst;
    end
  end

  always_comb begin
    d_inst_pc = '0;
    d_inst    = '0;
    if (!empty) begin
      d_inst_pc = pc_mem[rp_q];
      d_inst    = inst_mem[rp_q];
    end
  end

  assign d_inst_e_ = empty;
  assign f_full    = full;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fetch_dec_queue.sv
// Randomized and directed bench for fetch_dec_queue against a queue-based
// reference model of the instruction buffer.
module tb_fetch_dec_queue;
  localparam int ADDR  = 32;
  localparam int INST  = 32;
  localparam int DEPTH = 4;
  localparam int PTR   = $clog2(DEPTH);

  logic            clk = 1'b0;
  logic            reset_ = 1'b1;
  logic            flush = 1'b0;
  logic            f_inst_e_ = 1'b1;
  logic [ADDR-1:0] f_inst_pc = '0;
  logic [INST-1:0] f_inst = '0;
  logic            f_full;
  logic            d_inst_e_;
  logic [ADDR-1:0] d_inst_pc;
  logic [INST-1:0] d_inst;
  logic            d_stall = 1'b0;
  logic [PTR:0]    count;
  logic            overflow;

  int vectors = 0;
  int miscompares = 0;

  fetch_dec_queue #(.ADDR(ADDR), .INST(INST), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_    (reset_),
    .flush     (flush),
    .f_inst_e_ (f_inst_e_),
    .f_inst_pc (f_inst_pc),
    .f_inst    (f_inst),
    .f_full    (f_full),
    .d_inst_e_ (d_inst_e_),
    .d_inst_pc (d_inst_pc),
    .d_inst    (d_inst),
    .d_stall   (d_stall),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: an in-order list of held entries plus the sticky flag.
  logic [ADDR-1:0] m_pc   [$];
  logic [INST-1:0] m_inst [$];
  bit              m_ovf = 1'b0;

  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      m_pc.delete();
      m_inst.delete();
      m_ovf = 1'b0;
    end else if (flush) begin
      m_pc.delete();
      m_inst.delete();
      m_ovf = 1'b0;
    end else begin
      automatic int  sz    = m_pc.size();
      automatic bit  do_pop  = (sz != 0) && !d_stall;
      automatic bit  do_push = !f_inst_e_ && (sz < DEPTH);
      if (!f_inst_e_ && sz == DEPTH) m_ovf = 1'b1;
      if (do_pop) begin
        $display("deliver pc=%h inst=%h", m_pc[0], m_inst[0]);
        void'(m_pc.pop_front());
        void'(m_inst.pop_front());
      end
      if (do_push) begin
        m_pc.push_back(f_inst_pc);
        m_inst.push_back(f_inst);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    automatic int sz = m_pc.size();
    chk("d_inst_e_", 64'(d_inst_e_), 64'(sz == 0));
    chk("d_inst_pc", 64'(d_inst_pc), (sz != 0) ? 64'(m_pc[0]) : 64'd0);
    chk("d_inst",    64'(d_inst),    (sz != 0) ? 64'(m_inst[0]) : 64'd0);
    chk("count",     64'(count),     64'(sz));
    chk("f_full",    64'(f_full),    64'(sz == DEPTH));
    chk("overflow",  64'(overflow),  64'(m_ovf));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR-1:0] pc);
    f_inst_e_ = 1'b0;
    f_inst_pc = pc;
    f_inst    = $urandom;
    step();
  endtask

  initial begin
    // Reset / idle
    #1 reset_ = 1'b0;
    step();
    reset_ = 1'b1;
    step();
    chk("rst_e",    64'(d_inst_e_), 64'd1);
    chk("rst_cnt",  64'(count),     64'd0);
    chk("rst_full", 64'(f_full),    64'd0);
    chk("rst_inst", 64'(d_inst),    64'd0);
    chk("rst_ovf",  64'(overflow),  64'd0);

    // Fill and overflow
    d_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(ADDR'(4 * i));
    chk("fill_cnt",  64'(count),  64'd4);
    chk("fill_full", 64'(f_full), 64'd1);
    push(ADDR'(32'h10));
    f_inst_e_ = 1'b1;
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_cnt", 64'(count),    64'd4);
    d_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("drain_pc", 64'(d_inst_pc), 64'(4 * k));
      step();
    end
    chk("drain_e", 64'(d_inst_e_), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_ovf", 64'(overflow), 64'd0);

    // Concurrent push/pop with pointer wrap
    for (int i = 0; i < 10; i++) begin
      push(ADDR'(32'h200 + 4 * i));
      chk("stream_pc",  64'(d_inst_pc), 64'(32'h200 + 4 * i));
      chk("stream_cnt", 64'(count),     64'd1);
    end
    f_inst_e_ = 1'b1;
    step();
    chk("stream_end", 64'(count), 64'd0);

    // Stall hold
    d_stall = 1'b1;
    push(ADDR'(32'h300));
    push(ADDR'(32'h304));
    chk("hold_cnt2", 64'(count), 64'd2);
    push(ADDR'(32'h308));
    f_inst_e_ = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("hold_pc",  64'(d_inst_pc), 64'(32'h300));
      chk("hold_cnt", 64'(count),     64'd3);
      if (k < 2) step();
    end

    // Flush priority over push and pop
    d_stall   = 1'b0;
    flush     = 1'b1;
    f_inst_e_ = 1'b0;
    f_inst_pc = 32'hDEAD;
    step();
    flush     = 1'b0;
    f_inst_e_ = 1'b1;
    chk("fl_cnt", 64'(count),     64'd0);
    chk("fl_e",   64'(d_inst_e_), 64'd1);
    step();
    chk("fl_still_e", 64'(d_inst_e_), 64'd1);

    // Reset mid-operation
    d_stall = 1'b1;
    for (int i = 0; i < 3; i++) push(ADDR'(32'h400 + 4 * i));
    f_inst_e_ = 1'b1;
    chk("mid_cnt3", 64'(count), 64'd3);
    #2 reset_ = 1'b0;
    #1;
    chk("mid_e",    64'(d_inst_e_), 64'd1);
    chk("mid_cnt",  64'(count),     64'd0);
    chk("mid_full", 64'(f_full),    64'd0);
    step();
    reset_  = 1'b1;
    d_stall = 1'b0;
    push(ADDR'(32'h100));
    f_inst_e_ = 1'b1;
    chk("post_rst_pc", 64'(d_inst_pc), 64'h100);
    chk("post_rst_e",  64'(d_inst_e_), 64'd0);
    step();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      f_inst_e_ = ($urandom_range(0, 9) < 3);
      f_inst_pc = $urandom;
      f_inst    = $urandom;
      d_stall   = ($urandom_range(0, 9) < 4);
      flush     = ($urandom_range(0, 99) < 3);
      step();
    end
    f_inst_e_ = 1'b1;
    flush     = 1'b0;
    d_stall   = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
